rf_write_arbiter: RTL and testbench

Shares the register file's single write port between two writeback requesters: port 0 is the ALU writeback and port 1 is the memory/load writeback. Each port has a valid/ready handshake and a 2-entry FIFO. A round-robin arbiter drains the FIFOs into a registered write stage that drives the register file's `regWrite`/`writeReg`/`writeData` directly. Writes to register 0 are absorbed here and counted. A pending-write mask is exported to the hazard unit so it can stall reads of in-flight registers.

---
 rtl/rf_write_arbiter_if.sv | 42 ++++
 rtl/rf_write_arbiter.sv | 169 ++++++++++++++++
 tb/tb_rf_write_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rf_write_arbiter_if.sv
// rtl/rf_write_arbiter_if.sv - writeback request ports and register-file write bundle
interface rf_write_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    // Port 0: ALU writeback
    logic              req0_valid;
    logic              req0_ready;
    logic [ADDR_W-1:0] req0_addr;
    logic [DATA_W-1:0] req0_data;

    // Port 1: memory/load writeback
    logic              req1_valid;
    logic              req1_ready;
    logic [ADDR_W-1:0] req1_addr;
    logic [DATA_W-1:0] req1_data;

    // Register file write port and hazard/status outputs
    logic                     rf_we;
    logic [ADDR_W-1:0]        rf_waddr;
    logic [DATA_W-1:0]        rf_wdata;
    logic [(1<<ADDR_W)-1:0]   pending_mask;
    logic [7:0]               zero_drops;

    // Requester / observer side
    modport master (
        output req0_valid, req0_addr, req0_data,
        input  req0_ready,
        output req1_valid, req1_addr, req1_data,
        input  req1_ready,
        input  rf_we, rf_waddr, rf_wdata, pending_mask, zero_drops
    );

    // Arbiter side
    modport slave (
        input  req0_valid, req0_addr, req0_data,
        output req0_ready,
        input  req1_valid, req1_addr, req1_data,
        output req1_ready,
        output rf_we, rf_waddr, rf_wdata, pending_mask, zero_drops
    );
endinterface

// File: rtl/rf_write_arbiter.sv
// rtl/rf_write_arbiter.sv - two-port round-robin arbiter for the register file write port
module rf_write_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    rf_write_arbiter_if.slave bus
);
    localparam int NREG = 1 << ADDR_W;

    // Request side, gathered per port so both ports share one code path
    logic [1:0]        inValid;
    logic [ADDR_W-1:0] inAddr [2];
    logic [DATA_W-1:0] inData [2];
    logic [1:0]        portReady;
    logic [1:0]        accept;
    logic [1:0]        push;
    logic [1:0]        zeroHit;

    // Two-entry shift FIFOs: slot 0 is always the head
    logic [ADDR_W-1:0] qAddr  [2][2];
    logic [DATA_W-1:0] qData  [2][2];
    logic [1:0]        qCount [2];

    // Arbitration
    logic [1:0]        headValid;
    logic [1:0]        grant;
    logic              lastGrant;
    logic [ADDR_W-1:0] grantAddr;
    logic [DATA_W-1:0] grantData;

    // Write stage and status
    logic              rfWe;
    logic [ADDR_W-1:0] rfWaddr;
    logic [DATA_W-1:0] rfWdata;
    logic [7:0]        zeroDrops;
    logic [8:0]        zeroSum;
    logic [NREG-1:0]   pendingMask;

    assign inValid   = {bus.req1_valid, bus.req0_valid};
    assign inAddr[0] = bus.req0_addr;
    assign inAddr[1] = bus.req1_addr;
    assign inData[0] = bus.req0_data;
    assign inData[1] = bus.req1_data;

    // Acceptance: ready is a function of occupancy only, never of the same-cycle pop
    always_comb begin
        portReady = '0;
        accept    = '0;
        push      = '0;
        zeroHit   = '0;
        for (int p = 0; p < 2; p++) begin
            portReady[p] = (qCount[p] != 2'd2);
            accept[p]    = inValid[p] & portReady[p];
            zeroHit[p]   = accept[p] && (inAddr[p] == '0);
            push[p]      = accept[p] && (inAddr[p] != '0);
        end
    end

    // Round-robin grant: a lone head wins; under contention the port other than lastGrant wins
    always_comb begin
        headValid[0] = (qCount[0] != 2'd0);
        headValid[1] = (qCount[1] != 2'd0);
        grant[0]     = headValid[0] & (~headValid[1] | lastGrant);
        grant[1]     = headValid[1] & (~headValid[0] | ~lastGrant);
        grantAddr    = grant[1] ? qAddr[1][0] : qAddr[0][0];
        grantData    = grant[1] ? qData[1][0] : qData[0][0];
    end

    // Per-port FIFO update; push+pop keeps the count and shifts the tail forward
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int p = 0; p < 2; p++) begin
                qCount[p] <= 2'd0;
                for (int s = 0; s < 2; s++) begin
                    qAddr[p][s] <= '0;
                    qData[p][s] <= '0;
                end
            end
        end else begin
            for (int p = 0; p < 2; p++) begin
                case ({push[p], grant[p]})
                    2'b01: begin
                        qAddr[p][0] <= qAddr[p][1];
                        qData[p][0] <= qData[p][1];
                        qCount[p]   <= qCount[p] - 2'd1;
                    end
                    2'b10: begin
                        if (qCount[p] == 2'd0) begin
                            qAddr[p][0] <= inAddr[p];
                            qData[p][0] <= inData[p];
                        end else begin
                            qAddr[p][1] <= inAddr[p];
                            qData[p][1] <= inData[p];
                        end
                        qCount[p] <= qCount[p] + 2'd1;
                    end
                    2'b11: begin
                        if (qCount[p] == 2'd1) begin
                            qAddr[p][0] <= inAddr[p];
                            qData[p][0] <= inData[p];
                        end else begin
                            qAddr[p][0] <= qAddr[p][1];
                            qData[p][0] <= qData[p][1];
                            qAddr[p][1] <= inAddr[p];
                            qData[p][1] <= inData[p];
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Fairness pointer only moves when both heads compete; it records the winner
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lastGrant <= 1'b1;
        end else if (&headValid) begin
            lastGrant <= grant[1];
        end
    end

    // Write stage: one-cycle pulse per grant, address/data hold between writes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rfWe    <= 1'b0;
            rfWaddr <= '0;
            rfWdata <= '0;
        end else begin
            rfWe <= |grant;
            if (|grant) begin
                rfWaddr <= grantAddr;
                rfWdata <= grantData;
            end
        end
    end

    assign zeroSum = {1'b0, zeroDrops} + {8'd0, zeroHit[0]} + {8'd0, zeroHit[1]};

    // Saturating count of absorbed register-0 writes; both ports may add in one cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            zeroDrops <= 8'd0;
        end else begin
            zeroDrops <= zeroSum[8] ? 8'hFF : zeroSum[7:0];
        end
    end

    // Pending mask: every occupied FIFO slot plus the write stage while it is writing
    always_comb begin
        pendingMask = '0;
        for (int p = 0; p < 2; p++) begin
            if (qCount[p] != 2'd0) pendingMask[qAddr[p][0]] = 1'b1;
            if (qCount[p] == 2'd2) pendingMask[qAddr[p][1]] = 1'b1;
        end
        if (rfWe) pendingMask[rfWaddr] = 1'b1;
        pendingMask[0] = 1'b0;
    end

    assign bus.req0_ready   = portReady[0];
    assign bus.req1_ready   = portReady[1];
    assign bus.rf_we        = rfWe;
    assign bus.rf_waddr     = rfWaddr;
    assign bus.rf_wdata     = rfWdata;
    assign bus.pending_mask = pendingMask;
    assign bus.zero_drops   = zeroDrops;
endmodule

// File: tb/tb_rf_write_arbiter.sv
// tb/tb_rf_write_arbiter.sv - self-checking bench for rf_write_arbiter
module tb_rf_write_arbiter;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 32;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } ent_t;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          v0 = 1'b0;
    logic          v1 = 1'b0;
    logic [AW-1:0] a0 = '0;
    logic [AW-1:0] a1 = '0;
    logic [DW-1:0] d0 = '0;
    logic [DW-1:0] d1 = '0;

    rf_write_arbiter_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    assign bus.req0_valid = v0;
    assign bus.req0_addr  = a0;
    assign bus.req0_data  = d0;
    assign bus.req1_valid = v1;
    assign bus.req1_addr  = a1;
    assign bus.req1_data  = d1;

    rf_write_arbiter #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    int nAssert = 0;
    int nFail   = 0;
    int cycle   = 0;
    bit cmpEn   = 1'b0;

    // Reference model: per-port queues and the expected write-stage contents
    ent_t          q0[$];
    ent_t          q1[$];
    bit            mWe   = 1'b0;
    logic [AW-1:0] mAddr = '0;
    logic [DW-1:0] mData = '0;
    int            mZd   = 0;
    bit            mLast = 1'b1;
    bit            mAcc0 = 1'b0;
    bit            mAcc1 = 1'b0;

    int            logA[$];
    int            logC[$];
    logic [DW-1:0] logD[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nAssert++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    task automatic doReset();
        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    always @(posedge clk) cycle++;

    always @(posedge clk or posedge rst) begin : model
        int   g;
        int   nz;
        ent_t e;
        if (rst) begin
            q0.delete();
            q1.delete();
            mWe   = 1'b0;
            mAddr = '0;
            mData = '0;
            mZd   = 0;
            mLast = 1'b1;
            mAcc0 = 1'b0;
            mAcc1 = 1'b0;
        end else begin
            mAcc0 = v0 && (q0.size() < 2);
            mAcc1 = v1 && (q1.size() < 2);
            g = -1;
            if (q0.size() > 0 && q1.size() > 0) begin
                g = mLast ? 0 : 1;
                mLast = (g == 1);
            end else if (q0.size() > 0) begin
                g = 0;
            end else if (q1.size() > 0) begin
                g = 1;
            end
            mWe = (g >= 0);
            if (g == 0) begin
                e = q0.pop_front();
                mAddr = e.addr;
                mData = e.data;
            end else if (g == 1) begin
                e = q1.pop_front();
                mAddr = e.addr;
                mData = e.data;
            end
            nz = 0;
            if (mAcc0) begin
                if (a0 == '0) nz++;
                else q0.push_back({a0, d0});
            end
            if (mAcc1) begin
                if (a1 == '0) nz++;
                else q1.push_back({a1, d1});
            end
            mZd = (mZd + nz > 255) ? 255 : mZd + nz;
        end
    end

    always @(negedge clk) begin : compare
        logic [NR-1:0] em;
        if (cmpEn) begin
            em = '0;
            foreach (q0[i]) em[q0[i].addr] = 1'b1;
            foreach (q1[i]) em[q1[i].addr] = 1'b1;
            if (mWe) em[mAddr] = 1'b1;
            em[0] = 1'b0;
            check("req0_ready", bus.req0_ready, q0.size() < 2);
            check("req1_ready", bus.req1_ready, q1.size() < 2);
            check("rf_we", bus.rf_we, mWe);
            check("rf_waddr", bus.rf_waddr, mAddr);
            check("rf_wdata", bus.rf_wdata, mData);
            check("pending_mask", bus.pending_mask, em);
            check("zero_drops", bus.zero_drops, mZd);
        end
        if (bus.rf_we === 1'b1) begin
            logA.push_back(int'(bus.rf_waddr));
            logD.push_back(bus.rf_wdata);
            logC.push_back(cycle);
        end
    end

    initial begin : main
        bit saw0;
        bit saw1;
        bit sawWe;
        bit sawMask;
        int i0;
        int i1;
        int n;

        #1;
        rst   = 1'b1;
        cmpEn = 1'b1;
        cyc();
        check("reset req0_ready", bus.req0_ready, 1);
        check("reset req1_ready", bus.req1_ready, 1);
        check("reset rf_we", bus.rf_we, 0);
        check("reset rf_waddr", bus.rf_waddr, 0);
        check("reset rf_wdata", bus.rf_wdata, 0);
        check("reset pending_mask", bus.pending_mask, 0);
        check("reset zero_drops", bus.zero_drops, 0);
        cyc();
        rst = 1'b0;

        // Single write: accept at E0, write pulse in E1->E2
        v0 = 1'b1; a0 = 5'd5; d0 = 32'hDEADBEEF;
        cyc();
        v0 = 1'b0;
        check("single E0 rf_we", bus.rf_we, 0);
        check("single E0 mask5", bus.pending_mask[5], 1);
        cyc();
        check("single E1 rf_we", bus.rf_we, 1);
        check("single E1 rf_waddr", bus.rf_waddr, 5);
        check("single E1 rf_wdata", bus.rf_wdata, 32'hDEADBEEF);
        check("single E1 mask5", bus.pending_mask[5], 1);
        cyc();
        check("single E2 rf_we", bus.rf_we, 0);
        check("single E2 mask", bus.pending_mask, 0);
        check("single E2 waddr hold", bus.rf_waddr, 5);

        // Contention: 1..8 on port 0, 9..16 on port 1
        doReset();
        logA.delete(); logC.delete(); logD.delete();
        i0 = 0; i1 = 0; saw0 = 1'b0; saw1 = 1'b0;
        for (int c = 0; c < 60 && (i0 < 8 || i1 < 8); c++) begin
            v0 = (i0 < 8); a0 = AW'(1 + i0); d0 = 32'hA0000000 | DW'(i0);
            v1 = (i1 < 8); a1 = AW'(9 + i1); d1 = 32'hB0000000 | DW'(i1);
            cyc();
            if (mAcc0) i0++;
            if (mAcc1) i1++;
            if (bus.req0_ready === 1'b0) saw0 = 1'b1;
            if (bus.req1_ready === 1'b0) saw1 = 1'b1;
        end
        v0 = 1'b0; v1 = 1'b0;
        check("contention port0 accepted", i0, 8);
        check("contention port1 accepted", i1, 8);
        repeat (4) cyc();
        check("contention write count", logA.size(), 16);
        for (int k = 0; k < 16 && k < logA.size(); k++) begin
            check("contention waddr", logA[k], (k % 2 == 0) ? 1 + k / 2 : 9 + k / 2);
            check("contention wdata", logD[k],
                  (k % 2 == 0) ? (32'hA0000000 | DW'(k / 2)) : (32'hB0000000 | DW'(k / 2)));
            check("contention back-to-back", logC[k], logC[0] + k);
        end
        check("contention port0 saw not ready", saw0, 1);
        check("contention port1 saw not ready", saw1, 1);

        // Backpressure: port 1 writes 3,4,5,6 while port 0 floods
        doReset();
        logA.delete(); logC.delete(); logD.delete();
        i0 = 0; i1 = 0; saw1 = 1'b0;
        for (int c = 0; c < 60 && i1 < 4; c++) begin
            v0 = 1'b1; a0 = AW'(17 + (i0 % 8)); d0 = 32'hD0000000 | DW'(i0);
            v1 = 1'b1; a1 = AW'(3 + i1);        d1 = 32'hC0000000 | DW'(3 + i1);
            cyc();
            if (mAcc0) i0++;
            if (mAcc1) i1++;
            if (bus.req1_ready === 1'b0) saw1 = 1'b1;
        end
        v0 = 1'b0; v1 = 1'b0;
        check("backpressure port1 accepted", i1, 4);
        repeat (5) cyc();
        n = 0;
        for (int k = 0; k < logA.size(); k++) begin
            if (logA[k] >= 3 && logA[k] <= 6) begin
                check("backpressure order", logA[k], 3 + n);
                check("backpressure data", logD[k], 32'hC0000000 | DW'(3 + n));
                n++;
            end
        end
        check("backpressure port1 writes", n, 4);
        check("backpressure port1 saw not ready", saw1, 1);

        // Zero writes on both ports: saturates at 255, never writes, never pends
        doReset();
        sawWe = 1'b0; sawMask = 1'b0;
        v0 = 1'b1; a0 = '0; d0 = 32'h11111111;
        v1 = 1'b1; a1 = '0; d1 = 32'h22222222;
        for (int c = 1; c <= 130; c++) begin
            cyc();
            if (bus.rf_we !== 1'b0) sawWe = 1'b1;
            if (bus.pending_mask !== '0) sawMask = 1'b1;
            if (c == 1)   check("zero_drops after 1", bus.zero_drops, 2);
            if (c == 127) check("zero_drops after 127", bus.zero_drops, 254);
            if (c == 128) check("zero_drops after 128", bus.zero_drops, 255);
        end
        v0 = 1'b0; v1 = 1'b0;
        check("zero_drops final", bus.zero_drops, 255);
        check("zero rf_we seen", sawWe, 0);
        check("zero mask seen", sawMask, 0);

        // Reset while writes are queued and the write stage is active
        doReset();
        for (int c = 0; c < 6; c++) begin
            v0 = 1'b1; a0 = AW'(20 + c); d0 = DW'(c);
            v1 = 1'b1; a1 = AW'(26 + c); d1 = DW'(c + 100);
            cyc();
        end
        check("midflight pre rf_we", bus.rf_we, 1);
        check("midflight pre mask nonzero", bus.pending_mask != '0, 1);
        rst = 1'b1;
        #1;
        check("midflight rf_we", bus.rf_we, 0);
        check("midflight mask", bus.pending_mask, 0);
        check("midflight req0_ready", bus.req0_ready, 1);
        check("midflight req1_ready", bus.req1_ready, 1);
        v0 = 1'b0; v1 = 1'b0;
        cyc();
        cyc();
        rst = 1'b0;
        sawWe = 1'b0;
        repeat (5) begin
            cyc();
            if (bus.rf_we !== 1'b0) sawWe = 1'b1;
        end
        check("post-reset spurious rf_we", sawWe, 0);
        v0 = 1'b1; a0 = 5'd7; d0 = 32'h00007777;
        cyc();
        v0 = 1'b0;
        cyc();
        check("post-reset write rf_we", bus.rf_we, 1);
        check("post-reset write rf_waddr", bus.rf_waddr, 7);
        check("post-reset write rf_wdata", bus.rf_wdata, 32'h00007777);
        cyc();

        cmpEn = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
        $finish;
    end
endmodule
